// File: rtl/pingpong_window_reader.sv
// Walks the ping-pong read bank building 3x3 windows for the PE array, then hands the bank back.
// Latency: first address 1 cycle after i_buf_ready, window valid 11 cycles after; o_win holds under i_win_rdy stall.
module pingpong_window_reader #(
  parameter int IMG_W  = 34,
  parameter int IMG_H  = 34,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  en,
  input  logic                  i_buf_ready,
  output logic [ADDR_W-1:0]     o_conv_addr,
  input  logic [DATA_W-1:0]     i_conv_dout,
  output logic                  o_switch_pingpong,
  output logic [9*DATA_W-1:0]   o_win,
  output logic                  o_win_vld,
  input  logic                  i_win_rdy,
  output logic                  o_frame_done,
  output logic                  o_busy
);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, PRESENT, SWITCH} state_t;

  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - 3);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(IMG_H - 3);

  state_t             r_state;
  logic [ADDR_W-1:0]  r_row;
  logic [ADDR_W-1:0]  r_col;
  logic [3:0]         r_tap;
  logic [DATA_W-1:0]  r_win [9];

  logic               w_accept;
  logic               w_last_win;
  logic               w_col_wrap;
  logic [ADDR_W-1:0]  w_next_row;
  logic [ADDR_W-1:0]  w_next_col;

  function automatic logic [ADDR_W-1:0] tap_addr(input logic [ADDR_W-1:0] row,
                                                 input logic [ADDR_W-1:0] col,
                                                 input logic [3:0]        tap);
    logic [ADDR_W-1:0] ky;
    logic [ADDR_W-1:0] kx;
    ky = (tap >= 4'd6) ? ADDR_W'(2) : (tap >= 4'd3) ? ADDR_W'(1) : '0;
    kx = ADDR_W'(tap) - ky * ADDR_W'(3);
    return (row + ky) * STRIDE + col + kx;
  endfunction

  assign w_col_wrap = (r_col == LAST_COL);
  assign w_last_win = w_col_wrap && (r_row == LAST_ROW);
  assign w_next_col = w_col_wrap ? '0 : r_col + ADDR_W'(1);
  assign w_next_row = w_col_wrap ? (w_last_win ? '0 : r_row + ADDR_W'(1)) : r_row;

  // Frame done must coincide with the accepting handshake, so it cannot be registered.
  assign w_accept     = en && (r_state == PRESENT) && i_win_rdy;
  assign o_frame_done = w_accept && w_last_win;
  assign o_busy       = (r_state != IDLE);

  always_comb begin
    o_win = '0;
    for (int k = 0; k < 9; k++) begin
      o_win[DATA_W*k +: DATA_W] = r_win[k];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state           <= IDLE;
      r_row             <= '0;
      r_col             <= '0;
      r_tap             <= '0;
      o_conv_addr       <= '0;
      o_switch_pingpong <= 1'b0;
      o_win_vld         <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        r_win[k] <= '0;
      end
    end else if (en) begin
      case (r_state)
        IDLE: begin
          if (i_buf_ready) begin
            r_row       <= '0;
            r_col       <= '0;
            r_tap       <= '0;
            o_conv_addr <= '0;
            r_state     <= FETCH;
          end
        end
        // r_tap is the tap whose address is on the bus; its data lands one cycle later.
        FETCH: begin
          if (r_tap != 4'd0) begin
            r_win[r_tap - 4'd1] <= i_conv_dout;
          end
          if (r_tap == 4'd8) begin
            r_state <= DRAIN;
          end else begin
            r_tap       <= r_tap + 4'd1;
            o_conv_addr <= tap_addr(r_row, r_col, r_tap + 4'd1);
          end
        end
        DRAIN: begin
          r_win[8]  <= i_conv_dout;
          o_win_vld <= 1'b1;
          r_state   <= PRESENT;
        end
        PRESENT: begin
          if (i_win_rdy) begin
            o_win_vld <= 1'b0;
            r_row     <= w_next_row;
            r_col     <= w_next_col;
            r_tap     <= '0;
            if (w_last_win) begin
              r_state <= SWITCH;
            end else begin
              o_conv_addr <= tap_addr(w_next_row, w_next_col, 4'd0);
              r_state     <= FETCH;
            end
          end
        end
        SWITCH: begin
          o_switch_pingpong <= ~o_switch_pingpong;
          r_state           <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pingpong_window_reader.md
Name: pingpong_window_reader

Overview:
- Read-side consumer of the ping-pong frame buffer.
- Waits for the buffer to report a full frame in its read bank. Then walks that bank with `o_conv_addr`, assembling one 3x3 pixel window per convolution output position, and hands each window to the PE array over a valid/ready handshake.
- After the last window of the frame is accepted, toggles `o_switch_pingpong` to release the bank back to the writer.

Parameters:
- IMG_W, 34, frame width in pixels (row stride of buffer addressing).
- IMG_H, 34, frame height in pixels.
- ADDR_W, 16, buffer read-address width.
- DATA_W, 8, pixel width.

Ports:
- i_clk  input  1  single clock; buffer read port is on the same clock.
- i_rst_n  input  1  asynchronous active-low reset.
- en  input  1  global enable; when low, all state, counters and outputs hold.
- i_buf_ready  input  1  buffer read bank holds a complete frame (buffer's o_pl_buffer_ready).
- o_conv_addr  output  ADDR_W  buffer read address (to buffer i_conv_addr).
- i_conv_dout  input  DATA_W  buffer read data, valid exactly 1 cycle after the address is presented.
- o_switch_pingpong  output  1  level; toggles once per consumed frame (to buffer i_switch_pingpong).
- o_win  output  9*DATA_W  window; pixel k = ky*3+kx sits at [DATA_W*k +: DATA_W].
- o_win_vld  output  1  o_win valid.
- i_win_rdy  input  1  PE array accepts window.
- o_frame_done  output  1  one-cycle pulse in the cycle the last window is accepted.
- o_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values: o_conv_addr=0, o_switch_pingpong=0, o_win=0, o_win_vld=0, o_frame_done=0, o_busy=0. Row, col and tap counters are 0; FSM is in IDLE.
- Reset is asynchronous. Asserting it mid-frame aborts immediately with no switch toggle and discards any partial window.
- FSM states: IDLE, FETCH, DRAIN, PRESENT, SWITCH.
  - IDLE: when i_buf_ready=1, go to FETCH with row=col=tap=0.
  - FETCH: one tap per cycle for 9 cycles, tap 0..8 with ky=tap/3 and kx=tap%3.
    - o_conv_addr = (row+ky)*IMG_W + (col+kx), computed at full ADDR_W width, registered.
    - In the cycle after tap t is issued, i_conv_dout is captured into window slot t.
    - After tap 8 is issued, go to DRAIN.
  - DRAIN: capture slot 8, then go to PRESENT with o_win_vld=1 from the next cycle.
  - PRESENT: o_win and o_win_vld hold stable until i_win_rdy=1; an arbitrarily long stall loses nothing. On accept:
    - o_win_vld drops next cycle.
    - Advance col. On col wrap past IMG_W-3, reset col to 0 and increment row.
    - If the accepted window was row=IMG_H-3 and col=IMG_W-3, pulse o_frame_done and go to SWITCH; otherwise return to FETCH.
  - SWITCH: toggle o_switch_pingpong for one cycle, then go to IDLE.
    - i_buf_ready is ignored in the SWITCH cycle.
    - i_buf_ready is sampled again from the following IDLE cycle; the buffer must update ready within that cycle.
- Timing: i_buf_ready sampled high in IDLE at cycle 0 gives first address at cycle 1 and o_win_vld=1 at cycle 11. With i_win_rdy tied high, the window period is 11 cycles.
- Window count per frame: (IMG_W-2)*(IMG_H-2) = 1024 at defaults.
- Address boundary: the highest address issued is IMG_W*IMG_H-1 = 1155; no address ≥ IMG_W*IMG_H is ever issued.
- en low: freezes everything, including a pending capture. The buffer is assumed frozen by the same en, so read latency stays 1 cycle relative to enabled cycles.
- i_buf_ready dropping mid-frame is ignored; the frame is read to completion.
- If i_win_rdy is high in the same cycle o_win_vld rises, that counts as an accept.

Test Plan:
- Reset then idle: i_rst_n=0 then 1, i_buf_ready=0 for 50 cycles -> all outputs 0, o_busy=0, o_conv_addr=0.
- First window: buffer model returns the low byte of the address, i_buf_ready=1 at cycle 0, i_win_rdy=1 -> addresses 0,1,2,34,35,36,68,69,70 on cycles 1-9; o_win_vld at cycle 11; o_win bytes k0..k8 = 0,1,2,34,35,36,68,69,70.
- Row wrap: run to window 32 (row 1, col 0) -> taps 34,35,36,68,69,70,102,103,104.
- Backpressure: hold i_win_rdy=0 for 20 cycles on window 5 -> o_win stable and o_win_vld high throughout, no address change; accepted once on release, then the next fetch starts.
- Frame end: full frame -> last taps 1085,1086,1087,1119,1120,1121,1153,1154,1155 (bytes 61,62,63,95,96,97,129,130,131). Exactly 1024 accepts, one o_frame_done pulse, o_switch_pingpong 0->1. Second frame with i_buf_ready=1 -> toggles 1->0.
- Mid-frame reset / en: en=0 for 7 cycles during FETCH -> window contents identical to the en=1 run. Assert i_rst_n=0 at window 100 -> outputs reset immediately, no toggle, next frame restarts at address 0.
